// File: rtl/rom_stream_reader.sv
// Walks a contiguous ROM address range on command and streams each word out
// through a one-entry valid/ready output register.
module rom_stream_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_ce,
  output logic                  rom_ren,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_READ  | issuing ROM reads, one per free output slot
  // S_DRAIN | all words issued, waiting for the last one to be taken
  // S_DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  issue;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    issue       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_addr_d  = base_addr;
          remaining_d = len;
          state_d     = (len != '0) ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        // A read may replace the held word in the same cycle it is accepted.
        issue = !out_valid_q || out_ready;
        if (issue) begin
          out_data_d  = rom_data;
          out_valid_d = 1'b1;
          cur_addr_d  = cur_addr_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!out_valid_q || out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rom_addr  = cur_addr_q;
  assign rom_ce    = issue;
  assign rom_ren   = issue;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);

endmodule
